// File: rtl/bw_seq_multiplier.sv
// Sequential signed MxM modified Baugh-Wooley multiplier: one partial-product row per cycle into a carry-save layer, then a merge cycle.
// Optional feature BW_EARLY_ZERO_EN: a zero operand bypasses accumulation and yields product 0 one cycle after accept.
module bw_seq_multiplier #(
  parameter int M = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M-1:0]   a,
  input  logic [M-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*M-1:0] product,
  output logic           busy
);

  localparam int CW = $clog2(M);
  // Modified Baugh-Wooley correction: +2^M and +2^(2M-1).
  localparam logic [2*M-1:0] BW_CORR = {1'b1, {(M-2){1'b0}}, 1'b1, {M{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    MERGE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [M-1:0]   a_q, a_d;
  logic [M-1:0]   b_q, b_d;
  logic [M-1:0]   s_q, s_d;
  logic [M-1:0]   c_q, c_d;
  logic [M-1:0]   lo_q, lo_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2*M-1:0] product_q, product_d;
  logic           out_valid_q, out_valid_d;

  logic [M-1:0]   row_s;
  logic [M-1:0]   sum_s;
  logic [M-1:0]   carry_s;
  logic [M-1:0]   hi_s;
  logic           last_row_s;

  assign last_row_s = (count_q == CW'(M-1));

  // Row k of the BW array; sign-row and sign-column terms are inverted, their crossing is not.
  always_comb begin
    row_s = {M{1'b0}};
    for (int j = 0; j < M; j++) begin
      row_s[j] = (a_q[j] & b_q[count_q]) ^ ((j == M-1) != last_row_s);
    end
  end

  // One carry-save layer: row + S + C at the current weight; bit 0 of the sum is final.
  always_comb begin
    sum_s   = row_s ^ s_q ^ c_q;
    carry_s = (row_s & s_q) | (row_s & c_q) | (s_q & c_q);
    hi_s    = s_q + c_q;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    c_d         = c_q;
    lo_d        = lo_q;
    count_d     = count_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          s_d     = {M{1'b0}};
          c_d     = {M{1'b0}};
          lo_d    = {M{1'b0}};
          count_d = {CW{1'b0}};
          state_d = ACCUM;
`ifdef BW_EARLY_ZERO_EN
          if ((a == {M{1'b0}}) || (b == {M{1'b0}})) begin
            state_d   = DONE;
            product_d = {(2*M){1'b0}};
          end else begin
            state_d = ACCUM;
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        // S drops to the next weight; the retired bit enters lo from the top so row 0 lands at bit 0.
        s_d     = {1'b0, sum_s[M-1:1]};
        c_d     = carry_s;
        lo_d    = {sum_s[0], lo_q[M-1:1]};
        count_d = count_q + CW'(1);
        if (last_row_s) begin
          state_d = MERGE;
        end else begin
          state_d = ACCUM;
        end
      end
      MERGE: begin
        product_d   = {hi_s, lo_q} + BW_CORR;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        // out_valid is raised here on the bypass path, so handshake only once it is visible.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= {M{1'b0}};
      b_q         <= {M{1'b0}};
      s_q         <= {M{1'b0}};
      c_q         <= {M{1'b0}};
      lo_q        <= {M{1'b0}};
      count_q     <= {CW{1'b0}};
      product_q   <= {(2*M){1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      c_q         <= c_d;
      lo_q        <= lo_d;
      count_q     <= count_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule

// File: tb/tb_bw_seq_multiplier.sv
// Directed-vector and exhaustive checks for bw_seq_multiplier at M=5, covering latency, handshake stalls and reset abort.
module tb_bw_seq_multiplier;
  localparam int M = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [M-1:0]   a = 5'd0;
  logic [M-1:0]   b = 5'd0;
  logic           in_ready;
  logic           out_valid;
  logic           busy;
  logic [2*M-1:0] product;

  int checks = 0;
  int errors = 0;

  bw_seq_multiplier #(.M(M)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    logic [9:0] p;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input logic [4:0] ta, input logic [4:0] tb);
`ifdef BW_EARLY_ZERO_EN
    if ((ta == 5'd0) || (tb == 5'd0)) return 1;
`endif
    return M + 1;
  endfunction

  // Issue one operation at a negedge, measure latency, stall in DONE, then release.
  task automatic do_op(input logic [4:0] ta, input logic [4:0] tb, input logic [9:0] exp,
                       input int stall, input string name);
    int w;
    int edges;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    @(negedge clk);
    in_valid = 1'b0;
    a = ~ta;
    b = ~tb;
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    chk({name, "_latency"}, edges, exp_latency(ta, tb));
    chk({name, "_product"}, {22'd0, product}, {22'd0, exp});
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk({name, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({name, "_hold_product"}, {22'd0, product}, {22'd0, exp});
      chk({name, "_no_accept"}, {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_idle"}, {31'd0, busy}, 32'd0);
    chk({name, "_product_kept"}, {22'd0, product}, {22'd0, exp});
  endtask

  initial begin
    int low_cycles;
    int pa;
    int pb;
    logic [9:0] pe;

    vecs[0]  = '{5'h03, 5'h05, 10'h00F};
    vecs[1]  = '{5'h10, 5'h10, 10'h100};
    vecs[2]  = '{5'h10, 5'h0F, 10'h310};
    vecs[3]  = '{5'h1F, 5'h1F, 10'h001};
    vecs[4]  = '{5'h00, 5'h17, 10'h000};
    vecs[5]  = '{5'h0F, 5'h0F, 10'h0E1};
    vecs[6]  = '{5'h10, 5'h01, 10'h3F0};
    vecs[7]  = '{5'h07, 5'h1D, 10'h3EB};
    vecs[8]  = '{5'h0F, 5'h10, 10'h310};
    vecs[9]  = '{5'h18, 5'h04, 10'h3E0};
    vecs[10] = '{5'h05, 5'h00, 10'h000};
    vecs[11] = '{5'h0B, 5'h19, 10'h3B3};

    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_product", {22'd0, product}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].p, i % 3, $sformatf("vec%0d", i));
    end

    // in_ready low window with the consumer always ready.
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 5'h03;
    b = 5'h05;
    @(negedge clk);
    in_valid = 1'b0;
    low_cycles = 0;
    while (!in_ready && low_cycles < 20) begin
      low_cycles++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("in_ready_low_cycles", low_cycles, 32'd7);
    chk("in_ready_low_product", {22'd0, product}, 32'h00F);

    do_op(5'h03, 5'h05, 10'h00F, 4, "stall4");

    // Abort mid-accumulation at row k=2.
    in_valid = 1'b1;
    a = 5'h09;
    b = 5'h09;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_abort_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_product", {22'd0, product}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("after_abort_no_valid", {31'd0, out_valid}, 32'd0);
    do_op(5'h07, 5'h1D, 10'h3EB, 0, "after_abort");

    for (int ai = 0; ai < 32; ai++) begin
      for (int bi = 0; bi < 32; bi++) begin
        pa = (ai >= 16) ? ai - 32 : ai;
        pb = (bi >= 16) ? bi - 32 : bi;
        pe = 10'(pa * pb);
        do_op(5'(ai), 5'(bi), pe, int'($urandom_range(0, 2)), $sformatf("sweep_%0d_%0d", pa, pb));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
